// File: rtl/multicycle_control_unit_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit_if
//   Bundles every signal between the multi-cycle control unit and its
//   datapath: the instruction register, the memory port handshake, the
//   branch comparator, the mul/div unit and all control outputs.
//
//   master : the control unit (drives strobes and mux selects)
//   slave  : the datapath / memory / mul/div side
//
// Handshake semantics: memRead/memWrite are requests held high by the master
// until the slave answers with memReady in the same cycle; the transfer
// completes on the first clock edge where request and memReady are both
// high. mulDivStart is a single-cycle pulse; mulDivDone is a single-cycle
// pulse returned by the slave when the result is valid and is only
// observed while the master is waiting for it.
// ---------------------------------------------------------------------------
interface multicycle_control_unit_if;
    logic [31:0] instr;
    logic        memReady;
    logic        branchTaken;
    logic        mulDivDone;

    logic        pcWrite;
    logic        irWrite;
    logic        memRead;
    logic        memWrite;
    logic        regWrite;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [3:0]  ALUCtrl;
    logic [4:0]  immCtrl;
    logic [1:0]  memtoReg;
    logic        mulDivStart;
    logic [2:0]  mulDivOp;
    logic        illegal;
    logic        busError;
    logic [2:0]  state;

    modport master (
        input  instr, memReady, branchTaken, mulDivDone,
        output pcWrite, irWrite, memRead, memWrite, regWrite,
               ALUSrcA, ALUSrcB, ALUCtrl, immCtrl, memtoReg,
               mulDivStart, mulDivOp, illegal, busError, state
    );

    modport slave (
        output instr, memReady, branchTaken, mulDivDone,
        input  pcWrite, irWrite, memRead, memWrite, regWrite,
               ALUSrcA, ALUSrcB, ALUCtrl, immCtrl, memtoReg,
               mulDivStart, mulDivOp, illegal, busError, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//   FSM control unit for a multi-cycle RV32I core (optional M extension).
//   Sequences FETCH -> DECODE -> EXEC -> [MEM | MULDIV] -> WB, with a
//   timeout on memory waits and a sticky TRAP state left only by reset.
//
// Ports:
//   clk   - clock
//   rstn  - synchronous active-low reset; also forces all strobes low
//   bus   - master side of multicycle_control_unit_if (instr, memReady,
//           branchTaken, mulDivDone in; strobes, mux selects, sticky
//           illegal/busError and debug state out)
//
// Encodings:
//   ALUCtrl : 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA,
//             8 OR, 9 AND, 10 ADD with bit 0 of the result cleared (JALR)
//   immCtrl : one-hot 00001 I, 00010 S, 00100 B, 01000 U, 10000 J
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter bit EN_M_EXT     = 1'b1,
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 8
) (
    input logic clk,
    input logic rstn,
    multicycle_control_unit_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MULDIV = 3'd3,
        S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6
    } state_t;

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR  = 7'b1100011, OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011, OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2;
    localparam logic [3:0] ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8;
    localparam logic [3:0] ALU_AND = 4'd9, ALU_ADDJ = 4'd10;

    localparam logic [4:0] IMM_I = 5'b00001, IMM_S = 5'b00010, IMM_B = 5'b00100;
    localparam logic [4:0] IMM_U = 5'b01000, IMM_J = 5'b10000;

    // Counter value meaning "this is the last permitted low-ready cycle".
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       is_m;
    logic       legal;
    logic       unused_instr_bits;

    assign opcode            = bus.instr[6:0];
    assign rd                = bus.instr[11:7];
    assign funct3            = bus.instr[14:12];
    assign funct7            = bus.instr[31:25];
    assign unused_instr_bits = ^bus.instr[24:15];
    assign is_m              = EN_M_EXT && (opcode == OP_REG) && (funct7 == 7'b0000001);

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt,
                                          input logic is_reg);
        case (f3)
            3'b000:  alu_op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

    // Legality check of opcode plus the funct3/funct7 combinations it allows.
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
            OP_JALR: legal = (funct3 == 3'b000);
            OP_BR:   legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            OP_LOAD: legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            OP_ST:   legal = funct3 inside {3'b000, 3'b001, 3'b010};
            OP_IMM: begin
                if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else                       legal = 1'b1;
            end
            OP_REG: begin
                if (funct7 == 7'b0000000)      legal = 1'b1;
                else if (funct7 == 7'b0100000) legal = (funct3 == 3'b000) || (funct3 == 3'b101);
                else if (funct7 == 7'b0000001) legal = EN_M_EXT;
                else                           legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next-state logic. The wait counter defaults to 0 so it is already
    // clear on every entry to FETCH or MEM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            S_FETCH, S_MEM: begin
                if (bus.memReady) begin
                    if (state_q == S_FETCH)      state_d = S_DECODE;
                    else if (opcode == OP_LOAD)  state_d = S_WB;
                    else                         state_d = S_FETCH;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (opcode == OP_LOAD || opcode == OP_ST) state_d = S_MEM;
                else if (opcode == OP_BR)                 state_d = S_FETCH;
                else if (is_m)                            state_d = S_MULDIV;
                else                                      state_d = S_WB;
            end
            S_MULDIV: if (bus.mulDivDone) state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output logic
    logic       pc_write, ir_write, mem_read, mem_write, reg_write, md_start;
    logic [1:0] src_a, src_b, mem_to_reg;
    logic [3:0] alu_ctrl;
    logic [4:0] imm_ctrl;

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        md_start   = 1'b0;
        src_a      = 2'd0;
        src_b      = 2'd1;
        alu_ctrl   = ALU_ADD;
        imm_ctrl   = IMM_I;
        mem_to_reg = 2'd0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                src_a    = 2'd1;
                src_b    = 2'd2;
                ir_write = bus.memReady;
                pc_write = bus.memReady;
            end
            S_EXEC: begin
                case (opcode)
                    OP_LUI:   begin src_a = 2'd2; imm_ctrl = IMM_U; end
                    OP_AUIPC: begin src_a = 2'd1; imm_ctrl = IMM_U; end
                    OP_JAL:   begin src_a = 2'd1; imm_ctrl = IMM_J; pc_write = 1'b1; end
                    OP_JALR:  begin alu_ctrl = ALU_ADDJ; pc_write = 1'b1; end
                    OP_BR: begin
                        src_a    = 2'd1;
                        imm_ctrl = IMM_B;
                        pc_write = bus.branchTaken;
                    end
                    OP_ST:  imm_ctrl = IMM_S;
                    OP_IMM: alu_ctrl = alu_op(funct3, funct7[5], 1'b0);
                    OP_REG: begin
                        src_b    = 2'd0;
                        alu_ctrl = alu_op(funct3, funct7[5], 1'b1);
                        md_start = is_m;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                // Keep driving the address computation while the request waits.
                imm_ctrl  = (opcode == OP_ST) ? IMM_S : IMM_I;
                mem_read  = (opcode == OP_LOAD);
                mem_write = (opcode == OP_ST);
            end
            S_WB: begin
                reg_write = (rd != 5'd0);
                if (opcode == OP_LOAD)                         mem_to_reg = 2'd1;
                else if (opcode == OP_JAL || opcode == OP_JALR) mem_to_reg = 2'd2;
                else if (is_m)                                  mem_to_reg = 2'd3;
                else                                            mem_to_reg = 2'd0;
            end
            default: ;
        endcase
    end

    assign bus.pcWrite     = pc_write  & rstn;
    assign bus.irWrite     = ir_write  & rstn;
    assign bus.memRead     = mem_read  & rstn;
    assign bus.memWrite    = mem_write & rstn;
    assign bus.regWrite    = reg_write & rstn;
    assign bus.mulDivStart = md_start  & rstn;
    assign bus.ALUSrcA     = src_a;
    assign bus.ALUSrcB     = src_b;
    assign bus.ALUCtrl     = alu_ctrl;
    assign bus.immCtrl     = imm_ctrl;
    assign bus.memtoReg    = mem_to_reg;
    assign bus.mulDivOp    = funct3;
    assign bus.illegal     = illegal_q;
    assign bus.busError    = bus_err_q;
    assign bus.state       = state_q;
endmodule
